// File: rtl/hack_kbd_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: Hack key codes, PS/2 prefix bytes, RX states.
package hack_kbd_pkg;

    localparam logic [15:0] KEY_NEWLINE   = 16'd128;
    localparam logic [15:0] KEY_BACKSPACE = 16'd129;
    localparam logic [15:0] KEY_LEFT      = 16'd130;
    localparam logic [15:0] KEY_UP        = 16'd131;
    localparam logic [15:0] KEY_RIGHT     = 16'd132;
    localparam logic [15:0] KEY_DOWN      = 16'd133;
    localparam logic [15:0] KEY_HOME      = 16'd134;
    localparam logic [15:0] KEY_END       = 16'd135;
    localparam logic [15:0] KEY_PGUP      = 16'd136;
    localparam logic [15:0] KEY_PGDN      = 16'd137;
    localparam logic [15:0] KEY_INSERT    = 16'd138;
    localparam logic [15:0] KEY_DELETE    = 16'd139;
    localparam logic [15:0] KEY_ESC       = 16'd140;
    localparam logic [15:0] KEY_F1        = 16'd141;
    localparam logic [15:0] KEY_F12       = 16'd152;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/ps2_scancode_map.sv
// Combinational lookup from a set-2 scancode (with E0-extended flag) to a Hack key code; 0 = unmapped.
module ps2_scancode_map
    import hack_kbd_pkg::*;
(
    input  logic        ext,
    input  logic [7:0]  scan_byte,
    output logic [15:0] code
);

    always_comb begin
        code = 16'd0;
        if (ext) begin
            case (scan_byte)
                8'h6B: code = KEY_LEFT;
                8'h75: code = KEY_UP;
                8'h74: code = KEY_RIGHT;
                8'h72: code = KEY_DOWN;
                8'h6C: code = KEY_HOME;
                8'h69: code = KEY_END;
                8'h7D: code = KEY_PGUP;
                8'h7A: code = KEY_PGDN;
                8'h70: code = KEY_INSERT;
                8'h71: code = KEY_DELETE;
                default: code = 16'd0;
            endcase
        end else begin
            case (scan_byte)
                8'h1C: code = 16'd65;  8'h32: code = 16'd66;  8'h21: code = 16'd67;
                8'h23: code = 16'd68;  8'h24: code = 16'd69;  8'h2B: code = 16'd70;
                8'h34: code = 16'd71;  8'h33: code = 16'd72;  8'h43: code = 16'd73;
                8'h3B: code = 16'd74;  8'h42: code = 16'd75;  8'h4B: code = 16'd76;
                8'h3A: code = 16'd77;  8'h31: code = 16'd78;  8'h44: code = 16'd79;
                8'h4D: code = 16'd80;  8'h15: code = 16'd81;  8'h2D: code = 16'd82;
                8'h1B: code = 16'd83;  8'h2C: code = 16'd84;  8'h3C: code = 16'd85;
                8'h2A: code = 16'd86;  8'h1D: code = 16'd87;  8'h22: code = 16'd88;
                8'h35: code = 16'd89;  8'h1A: code = 16'd90;
                8'h45: code = 16'd48;  8'h16: code = 16'd49;  8'h1E: code = 16'd50;
                8'h26: code = 16'd51;  8'h25: code = 16'd52;  8'h2E: code = 16'd53;
                8'h36: code = 16'd54;  8'h3D: code = 16'd55;  8'h3E: code = 16'd56;
                8'h46: code = 16'd57;
                8'h29: code = 16'd32;
                8'h5A: code = KEY_NEWLINE;
                8'h66: code = KEY_BACKSPACE;
                8'h76: code = KEY_ESC;
                8'h05: code = KEY_F1;
                8'h06: code = 16'd142;  8'h04: code = 16'd143;  8'h0C: code = 16'd144;
                8'h03: code = 16'd145;  8'h0B: code = 16'd146;  8'h83: code = 16'd147;
                8'h0A: code = 16'd148;  8'h01: code = 16'd149;  8'h09: code = 16'd150;
                8'h78: code = 16'd151;
                8'h07: code = KEY_F12;
                default: code = 16'd0;
            endcase
        end
    end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: conditions ps_clk/ps_data, deframes bytes, tracks the held Hack key code.
// Define PS2_EXT_KEYS_EN to decode E0-prefixed keys (arrows, Home/End, PgUp/PgDn, Ins/Del).
module ps2_keyboard_rx
    import hack_kbd_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic        clk_50,
    input  logic        rst,
    input  logic        ps_clk,
    input  logic        ps_data,
    output logic [15:0] key_code,
    output logic        key_strobe,
    output logic        frame_err
);

    localparam int FCW = $clog2(FILTER_LEN) + 1;
    localparam int TCW = $clog2(TIMEOUT_CYC + 1);

    logic [1:0]     clk_sync, data_sync;
    logic           filt_clk;
    logic [FCW-1:0] filt_cnt;
    logic           fall_pulse, sample_bit;
    logic [TCW-1:0] timer;
    logic           timeout;

    rx_state_t      state, state_n;
    logic [7:0]     shift_reg, shift_n;
    logic [2:0]     bit_cnt, bit_cnt_n;
    logic           parity_bit, parity_n;
    logic           byte_valid, byte_valid_n, frame_err_n;

    logic           brk_flag, ext_flag;
    logic [15:0]    map_code;

    // Synchronise both lines, then only accept a ps_clk level after FILTER_LEN agreeing samples.
    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) begin
            clk_sync   <= 2'b11;
            data_sync  <= 2'b11;
            filt_clk   <= 1'b1;
            filt_cnt   <= '0;
            fall_pulse <= 1'b0;
            sample_bit <= 1'b1;
        end else begin
            clk_sync   <= {clk_sync[0], ps_clk};
            data_sync  <= {data_sync[0], ps_data};
            fall_pulse <= 1'b0;
            sample_bit <= data_sync[1];
            if (clk_sync[1] != filt_clk) begin
                if (filt_cnt == FCW'(FILTER_LEN - 1)) begin
                    filt_clk   <= clk_sync[1];
                    filt_cnt   <= '0;
                    fall_pulse <= filt_clk;
                end else begin
                    filt_cnt <= filt_cnt + FCW'(1);
                end
            end else begin
                filt_cnt <= '0;
            end
        end
    end

    assign timeout = (timer >= TCW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) begin
            state      <= RX_IDLE;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            parity_bit <= 1'b0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            timer      <= '0;
        end else begin
            state      <= state_n;
            shift_reg  <= shift_n;
            bit_cnt    <= bit_cnt_n;
            parity_bit <= parity_n;
            byte_valid <= byte_valid_n;
            frame_err  <= frame_err_n;
            if (state == RX_IDLE || fall_pulse)
                timer <= '0;
            else if (!timeout)
                timer <= timer + TCW'(1);
        end
    end

    // Frame FSM: one step per filtered falling edge; a stalled partial frame is dropped on timeout.
    always_comb begin
        state_n      = state;
        shift_n      = shift_reg;
        bit_cnt_n    = bit_cnt;
        parity_n     = parity_bit;
        byte_valid_n = 1'b0;
        frame_err_n  = 1'b0;
        if (state != RX_IDLE && timeout && !fall_pulse) begin
            state_n     = RX_IDLE;
            frame_err_n = 1'b1;
        end else if (fall_pulse) begin
            case (state)
                RX_IDLE: begin
                    if (!sample_bit) begin
                        state_n   = RX_DATA;
                        bit_cnt_n = '0;
                    end else begin
                        frame_err_n = 1'b1;
                    end
                end
                RX_DATA: begin
                    shift_n = {sample_bit, shift_reg[7:1]};
                    if (bit_cnt == 3'd7)
                        state_n = RX_PARITY;
                    else
                        bit_cnt_n = bit_cnt + 3'd1;
                end
                RX_PARITY: begin
                    parity_n = sample_bit;
                    state_n  = RX_STOP;
                end
                RX_STOP: begin
                    if (sample_bit && (^{shift_reg, parity_bit}))
                        byte_valid_n = 1'b1;
                    else
                        frame_err_n = 1'b1;
                    state_n = RX_IDLE;
                end
                default: state_n = RX_IDLE;
            endcase
        end
    end

    ps2_scancode_map u_map (
        .ext       (ext_flag),
        .scan_byte (shift_reg),
        .code      (map_code)
    );

    // Make/break decoder: last make wins; a break only clears the key currently held.
    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) begin
            key_code   <= '0;
            key_strobe <= 1'b0;
            brk_flag   <= 1'b0;
            ext_flag   <= 1'b0;
        end else begin
            key_strobe <= 1'b0;
            if (byte_valid) begin
                if (shift_reg == PS2_BREAK) begin
                    brk_flag <= 1'b1;
                end else if (shift_reg == PS2_EXT) begin
`ifdef PS2_EXT_KEYS_EN
                    ext_flag <= 1'b1;
`else
                    ext_flag <= 1'b0;
`endif
                end else begin
                    brk_flag <= 1'b0;
                    ext_flag <= 1'b0;
                    if (!brk_flag && map_code != 16'd0 && map_code != key_code) begin
                        key_code   <= map_code;
                        key_strobe <= 1'b1;
                    end else if (brk_flag && map_code != 16'd0 && map_code == key_code) begin
                        key_code   <= 16'd0;
                        key_strobe <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Randomised scoreboard bench for ps2_keyboard_rx against a key-state model built from the scancode tables.
module tb_ps2_keyboard_rx;

    localparam int HALF    = 40;
    localparam int GAP     = 60;
    localparam int TIMEOUT = 1500;

    localparam logic [7:0] LETTERS [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                            8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                            8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                            8'h35, 8'h1A};
    localparam logic [7:0] DIGITS [10]  = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                            8'h3E, 8'h46};
    localparam logic [7:0] FKEYS [12]   = '{8'h05, 8'h06, 8'h04, 8'h0C, 8'h03, 8'h0B, 8'h83, 8'h0A,
                                            8'h01, 8'h09, 8'h78, 8'h07};
    localparam logic [7:0] EXTKEYS [10] = '{8'h6B, 8'h75, 8'h74, 8'h72, 8'h6C, 8'h69, 8'h7D, 8'h7A,
                                            8'h70, 8'h71};

    logic        clk_50, rst, ps_clk, ps_data;
    logic [15:0] key_code;
    logic        key_strobe, frame_err;

    int          compared = 0;
    int          mismatched = 0;
    int          err_seen = 0;
    int          err_exp = 0;
    logic [15:0] exp_q[$];

    bit          m_brk, m_ext;
    logic [15:0] m_held;

    ps2_keyboard_rx #(.FILTER_LEN(8), .TIMEOUT_CYC(TIMEOUT)) dut (
        .clk_50     (clk_50),
        .rst        (rst),
        .ps_clk     (ps_clk),
        .ps_data    (ps_data),
        .key_code   (key_code),
        .key_strobe (key_strobe),
        .frame_err  (frame_err)
    );

    initial begin
        clk_50 = 1'b0;
        forever #10 clk_50 = ~clk_50;
    end

    function automatic logic [15:0] ref_map(input logic [7:0] b, input bit e);
        if (e) begin
            for (int i = 0; i < 10; i++) if (b == EXTKEYS[i]) return 16'(130 + i);
            return 16'd0;
        end
        for (int i = 0; i < 26; i++) if (b == LETTERS[i]) return 16'(65 + i);
        for (int i = 0; i < 10; i++) if (b == DIGITS[i]) return 16'(48 + i);
        for (int i = 0; i < 12; i++) if (b == FKEYS[i]) return 16'(141 + i);
        case (b)
            8'h29:   return 16'd32;
            8'h5A:   return 16'd128;
            8'h66:   return 16'd129;
            8'h76:   return 16'd140;
            default: return 16'd0;
        endcase
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        logic [15:0] m;
        if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else if (b == 8'hE0) begin
`ifdef PS2_EXT_KEYS_EN
            m_ext = 1'b1;
`endif
        end else begin
            m = ref_map(b, m_ext);
            if (!m_brk && m != 0 && m != m_held) begin
                m_held = m;
                exp_q.push_back(m);
            end else if (m_brk && m != 0 && m == m_held) begin
                m_held = 16'd0;
                exp_q.push_back(16'd0);
            end
            m_brk = 1'b0;
            m_ext = 1'b0;
        end
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk_50);
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive nbits of an 11-bit frame; a 3-cycle low glitch can be inserted in bit 5's high phase.
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits, input bit glitch);
        logic [10:0] bits;
        bits = {1'b1, (bad_par ? ^b : ~^b), b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps_data = bits[i];
            if (glitch && i == 5) begin
                wait_cycles(15);
                ps_clk = 1'b0;
                wait_cycles(3);
                ps_clk = 1'b1;
                wait_cycles(HALF - 18);
            end else begin
                wait_cycles(HALF);
            end
            ps_clk = 1'b0;
            wait_cycles(HALF);
            ps_clk = 1'b1;
        end
        ps_data = 1'b1;
    endtask

    task automatic applyStimulus(input logic [7:0] b, input bit bad_par, input bit glitch);
        if (bad_par) err_exp++;
        else model_byte(b);
        send_frame(b, bad_par, 11, glitch);
        wait_cycles(GAP);
        @(negedge clk_50);
        checkOutput($sformatf("key_code after %02h", b), key_code, m_held);
        checkOutput("frame_err count", err_seen, err_exp);
    endtask

    // Monitor: every strobe must match the next expected key code from the model.
    always @(negedge clk_50) begin
        if (!rst) begin
            if (frame_err) err_seen++;
            if (key_strobe) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected key_strobe", key_code, -1);
                end else begin
                    checkOutput("strobed key_code", key_code, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [7:0] b, last_make;
        int r;
        rst = 1'b1;
        ps_clk = 1'b1;
        ps_data = 1'b1;
        m_brk = 1'b0; m_ext = 1'b0; m_held = 16'd0;
        last_make = 8'h1C;
        wait_cycles(5);
        @(negedge clk_50);
        checkOutput("reset key_code", key_code, 0);
        checkOutput("reset key_strobe", key_strobe, 0);
        checkOutput("reset frame_err", frame_err, 0);
        rst = 1'b0;
        wait_cycles(20);

        applyStimulus(8'h1C, 0, 0);
        applyStimulus(8'hF0, 0, 0);
        applyStimulus(8'h1C, 0, 0);
        applyStimulus(8'h1C, 0, 0);
        applyStimulus(8'h32, 0, 0);
        applyStimulus(8'hF0, 0, 0);
        applyStimulus(8'h1C, 0, 0);
        applyStimulus(8'h32, 0, 0);
        applyStimulus(8'hF0, 0, 0);
        applyStimulus(8'h32, 0, 0);
        applyStimulus(8'h5A, 1, 0);
        applyStimulus(8'h66, 0, 0);

        err_exp++;
        send_frame(8'h29, 0, 5, 0);
        wait_cycles(TIMEOUT + 200);
        @(negedge clk_50);
        checkOutput("timeout frame_err count", err_seen, err_exp);
        applyStimulus(8'h29, 0, 0);
        applyStimulus(8'h1C, 0, 1);

        applyStimulus(8'hE0, 0, 0);
        applyStimulus(8'h75, 0, 0);
        applyStimulus(8'hE0, 0, 0);
        applyStimulus(8'hF0, 0, 0);
        applyStimulus(8'h75, 0, 0);

        send_frame(8'h32, 0, 4, 0);
        rst = 1'b1;
        m_brk = 1'b0; m_ext = 1'b0; m_held = 16'd0;
        wait_cycles(4);
        rst = 1'b0;
        wait_cycles(20);
        @(negedge clk_50);
        checkOutput("key_code after mid-frame reset", key_code, 0);
        applyStimulus(8'h24, 0, 0);

        for (int n = 0; n < 28; n++) begin
            r = $urandom_range(0, 99);
            if (r < 40) begin
                case ($urandom_range(0, 3))
                    0: b = LETTERS[$urandom_range(0, 25)];
                    1: b = DIGITS[$urandom_range(0, 9)];
                    2: b = FKEYS[$urandom_range(0, 11)];
                    default: b = 8'h29;
                endcase
                last_make = b;
                applyStimulus(b, 0, 0);
            end else if (r < 65) begin
                applyStimulus(8'hF0, 0, 0);
                b = ($urandom_range(0, 1) == 0) ? last_make : LETTERS[$urandom_range(0, 25)];
                applyStimulus(b, 0, 0);
            end else if (r < 75) begin
                applyStimulus(8'hE0, 0, 0);
                applyStimulus(EXTKEYS[$urandom_range(0, 9)], 0, 0);
            end else if (r < 88) begin
                b = 8'($urandom_range(0, 255));
                if (b == 8'hF0 || b == 8'hE0) b = 8'h00;
                applyStimulus(b, 0, ($urandom_range(0, 1) == 1));
            end else begin
                applyStimulus(LETTERS[$urandom_range(0, 25)], 1, 0);
            end
        end

        wait_cycles(200);
        @(negedge clk_50);
        checkOutput("pending strobes", exp_q.size(), 0);
        checkOutput("final key_code", key_code, m_held);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
